// File: rtl/chart_pan_if.sv
// chart_pan_if: drag-input / pan-output bundle between the drag stage,
// the pan integrator and the chart renderer.
//   left_mouse   : left button level
//   x/y_mouse_pos: unsigned drag magnitudes (11 bits)
//   minus_x/y    : drag direction flags (1 = positive delta)
//   frame_start  : one-cycle pulse at each frame start
//   center       : one-cycle recenter request
//   x/y_offset   : signed pan offsets presented to the renderer
//   dragging     : high while a drag is being integrated
// master drives the inputs and observes the outputs; slave is the pan block.
interface chart_pan_if #(
  parameter int OFFSET_W = 12
);
  logic                       left_mouse;
  logic [10:0]                x_mouse_pos;
  logic [10:0]                y_mouse_pos;
  logic                       minus_x;
  logic                       minus_y;
  logic                       frame_start;
  logic                       center;
  logic signed [OFFSET_W-1:0] x_offset;
  logic signed [OFFSET_W-1:0] y_offset;
  logic                       dragging;

  modport master (
    output left_mouse, x_mouse_pos, y_mouse_pos, minus_x, minus_y,
           frame_start, center,
    input  x_offset, y_offset, dragging
  );

  modport slave (
    input  left_mouse, x_mouse_pos, y_mouse_pos, minus_x, minus_y,
           frame_start, center,
    output x_offset, y_offset, dragging
  );
endinterface

// File: rtl/chart_pan.sv
// chart_pan: integrates mouse drags into saturated signed pan offsets for
// the chart (x = time axis, y = voltage axis) and publishes them to the
// renderer only on frame boundaries.
// Ports:
//   clk  : system clock (same clock as the drag stage)
//   rst  : asynchronous, active-low reset
//   bus  : chart_pan_if.slave (drag inputs, frame/center pulses, offsets out)
//
// state  | meaning
// IDLE   | no drag; live tracks base; press captures the drag origin d0
// DRAG   | live = sat(base + delta - d0) every cycle; release -> COMMIT
// COMMIT | one cycle: base <= live, inputs ignored
// HOLD   | recentered while button still held; wait for release
module chart_pan #(
  parameter int OFFSET_W = 12,
  parameter int MAX_X    = 1023,
  parameter int MAX_Y    = 511
) (
  input  logic        clk,
  input  logic        rst,
  chart_pan_if.slave  bus
);

  localparam int DELTA_W = 12;
  localparam int SUM_W   = OFFSET_W + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAG   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic signed [SUM_W-1:0] LIM_X = SUM_W'(MAX_X);
  localparam logic signed [SUM_W-1:0] LIM_Y = SUM_W'(MAX_Y);

  logic [1:0]                 r_state;
  logic [1:0]                 w_state_nxt;
  logic signed [OFFSET_W-1:0] r_base_x, r_base_y;
  logic signed [OFFSET_W-1:0] r_live_x, r_live_y;
  logic signed [DELTA_W-1:0]  r_d0_x, r_d0_y;
  logic signed [OFFSET_W-1:0] r_x_offset, r_y_offset;
  logic                       r_dragging;

  logic signed [DELTA_W-1:0]  w_dx, w_dy;
  logic signed [SUM_W-1:0]    w_sum_x, w_sum_y;
  logic signed [OFFSET_W-1:0] w_sat_x, w_sat_y;

  function automatic logic signed [OFFSET_W-1:0] sat(
    input logic signed [SUM_W-1:0] v,
    input logic signed [SUM_W-1:0] lim
  );
    logic signed [SUM_W-1:0] r;
    if (v > lim)       r = lim;
    else if (v < -lim) r = -lim;
    else               r = v;
    return OFFSET_W'(r);
  endfunction

  // 11-bit magnitude fits a 12-bit signed value in either direction
  assign w_dx = bus.minus_x ? $signed({1'b0, bus.x_mouse_pos})
                            : -$signed({1'b0, bus.x_mouse_pos});
  assign w_dy = bus.minus_y ? $signed({1'b0, bus.y_mouse_pos})
                            : -$signed({1'b0, bus.y_mouse_pos});

  // Subtracting d0 cancels whatever magnitude the drag stage still held
  // when the button went down, so every drag starts from zero.
  assign w_sum_x = SUM_W'(r_base_x) + SUM_W'(w_dx) - SUM_W'(r_d0_x);
  assign w_sum_y = SUM_W'(r_base_y) + SUM_W'(w_dy) - SUM_W'(r_d0_y);
  assign w_sat_x = sat(w_sum_x, LIM_X);
  assign w_sat_y = sat(w_sum_y, LIM_Y);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.left_mouse)  w_state_nxt = S_DRAG;
      S_DRAG:   if (!bus.left_mouse) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      S_HOLD:   if (!bus.left_mouse) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    // HOLD keeps a still-held drag from being re-applied after recenter
    if (bus.center) w_state_nxt = bus.left_mouse ? S_HOLD : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_dragging <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dragging <= (w_state_nxt == S_DRAG);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base_x <= '0;
      r_base_y <= '0;
      r_live_x <= '0;
      r_live_y <= '0;
      r_d0_x   <= '0;
      r_d0_y   <= '0;
    end else if (bus.center) begin
      r_base_x <= '0;
      r_base_y <= '0;
      r_live_x <= '0;
      r_live_y <= '0;
      r_d0_x   <= '0;
      r_d0_y   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_live_x <= r_base_x;
          r_live_y <= r_base_y;
          if (bus.left_mouse) begin
            r_d0_x <= w_dx;
            r_d0_y <= w_dy;
          end
        end
        S_DRAG: begin
          r_live_x <= w_sat_x;
          r_live_y <= w_sat_y;
        end
        S_COMMIT: begin
          r_base_x <= r_live_x;
          r_base_y <= r_live_y;
        end
        S_HOLD: begin
          r_base_x <= '0;
          r_base_y <= '0;
          r_live_x <= '0;
          r_live_y <= '0;
        end
        default: ;
      endcase
    end
  end

  // Offsets change only on frame boundaries so a frame never tears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x_offset <= '0;
      r_y_offset <= '0;
    end else if (bus.frame_start) begin
      r_x_offset <= bus.center ? '0 : r_live_x;
      r_y_offset <= bus.center ? '0 : r_live_y;
    end
  end

  assign bus.x_offset = r_x_offset;
  assign bus.y_offset = r_y_offset;
  assign bus.dragging = r_dragging;

endmodule

// File: tb/tb_chart_pan.sv
// tb_chart_pan: table-driven check of chart_pan. Each record holds the
// inputs for one clock and the outputs expected just after that edge.
module tb_chart_pan;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  chart_pan_if #(.OFFSET_W(12)) bus ();

  chart_pan #(.OFFSET_W(12), .MAX_X(1023), .MAX_Y(511)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lm;
    logic [10:0] x;
    logic [10:0] y;
    logic        mx;
    logic        my;
    logic        fs;
    logic        c;
    int          ex;
    int          ey;
    logic        ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int lm, input int x, input int y, input int mx,
                     input int my, input int fs, input int c,
                     input int ex, input int ey, input int ed);
    vec_t v;
    v.lm = lm[0]; v.x = x[10:0]; v.y = y[10:0]; v.mx = mx[0]; v.my = my[0];
    v.fs = fs[0]; v.c = c[0]; v.ex = ex; v.ey = ey; v.ed = ed[0];
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.left_mouse  = v.lm;
    bus.x_mouse_pos = v.x;
    bus.y_mouse_pos = v.y;
    bus.minus_x     = v.mx;
    bus.minus_y     = v.my;
    bus.frame_start = v.fs;
    bus.center      = v.c;
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(posedge clk);
    #1;
    chk({tag, " x_offset"}, int'(bus.x_offset), v.ex);
    chk({tag, " y_offset"}, int'(bus.y_offset), v.ey);
    chk({tag, " dragging"}, int'(bus.dragging), int'(v.ed));
  endtask

  int b;
  vec_t v;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    v = '{lm:0, x:0, y:0, mx:0, my:0, fs:0, c:0, ex:0, ey:0, ed:0};
    drive(v);

    // reset, no activity
    add(0,0,0,0,0,1,0, 0,0,0);
    add(0,0,0,0,0,0,0, 0,0,0);
    add(0,0,0,0,0,1,0, 0,0,0);

    // two identical x drags: press at 100, ramp to 300, release, commit
    for (int r = 0; r < 2; r++) begin
      b = 200 * r;
      add(1,100,0,1,1,0,0, b,0,1);
      for (int k = 1; k <= 10; k++) add(1,100+20*k,0,1,1,0,0, b,0,1);
      add(0,300,0,1,1,0,0, b,0,0);
      add(0,300,0,1,1,0,0, b,0,0);
      add(0,300,0,1,1,1,0, b+200,0,0);
    end

    // y drag toward -y, 0..700, clamps at -511
    add(1,300,0,1,0,0,0, 400,0,1);
    for (int k = 1; k <= 5; k++) add(1,300,100*k,1,0,0,0, 400,0,1);
    add(1,300,600,1,0,1,0, 400,-500,1);
    add(1,300,700,1,0,1,0, 400,-511,1);
    add(0,300,700,1,0,0,0, 400,-511,0);
    add(0,300,700,1,0,0,0, 400,-511,0);
    add(0,300,700,1,0,1,0, 400,-511,0);
    // further -50 stays at the limit
    add(1,300,0,1,0,0,0, 400,-511,1);
    add(1,300,50,1,0,0,0, 400,-511,1);
    add(0,300,50,1,0,0,0, 400,-511,0);
    add(0,300,50,1,0,0,0, 400,-511,0);
    add(0,300,50,1,0,1,0, 400,-511,0);

    // mid-frame x change: outputs wait for frame_start
    add(1,0,50,1,0,0,0, 400,-511,1);
    add(1,50,50,1,0,0,0, 400,-511,1);
    add(1,80,50,1,0,0,0, 400,-511,1);
    add(1,80,50,1,0,1,0, 480,-511,1);
    add(0,80,50,1,0,0,0, 480,-511,0);
    add(0,80,50,1,0,0,0, 480,-511,0);

    // center mid-drag with button held -> HOLD, no commit on release
    add(1,0,50,1,0,0,0, 480,-511,1);
    add(1,20,50,1,0,0,0, 480,-511,1);
    add(1,40,50,1,0,0,1, 480,-511,0);
    add(1,60,50,1,0,1,0, 0,0,0);
    add(1,80,50,1,0,0,0, 0,0,0);
    add(0,80,50,1,0,0,0, 0,0,0);
    add(0,80,50,1,0,1,0, 0,0,0);
    add(0,80,50,1,0,0,0, 0,0,0);

    // center and frame_start in the same cycle load zero
    add(1,0,50,1,0,0,0, 0,0,1);
    add(1,100,50,1,0,0,0, 0,0,1);
    add(1,100,50,1,0,1,0, 100,0,1);
    add(1,150,50,1,0,1,1, 0,0,0);
    add(0,150,50,1,0,0,0, 0,0,0);

    // release coincident with center: no commit
    add(1,0,50,1,0,0,0, 0,0,1);
    add(1,100,50,1,0,0,0, 0,0,1);
    add(0,100,50,1,0,0,1, 0,0,0);
    add(0,100,50,1,0,0,0, 0,0,0);
    add(0,100,50,1,0,1,0, 0,0,0);

    #3;
    chk("reset x_offset", int'(bus.x_offset), 0);
    chk("reset y_offset", int'(bus.y_offset), 0);
    chk("reset dragging", int'(bus.dragging), 0);
    #9 rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // asynchronous reset mid-drag
    v = '{lm:1, x:0,   y:0, mx:1, my:1, fs:0, c:0, ex:0,   ey:0, ed:1};
    apply(v, "ar_press");
    v = '{lm:1, x:200, y:0, mx:1, my:1, fs:0, c:0, ex:0,   ey:0, ed:1};
    apply(v, "ar_move");
    v = '{lm:1, x:200, y:0, mx:1, my:1, fs:1, c:0, ex:200, ey:0, ed:1};
    apply(v, "ar_frame");
    v = '{lm:1, x:250, y:0, mx:1, my:1, fs:0, c:0, ex:0,   ey:0, ed:1};
    drive(v);
    #2 rst = 1'b0;
    #1;
    chk("ar_async x_offset", int'(bus.x_offset), 0);
    chk("ar_async y_offset", int'(bus.y_offset), 0);
    chk("ar_async dragging", int'(bus.dragging), 0);
    #3 rst = 1'b1;
    // button still held: IDLE re-enters DRAG and captures d0 = 250
    apply(v, "ar_repress");
    v = '{lm:1, x:250, y:0, mx:1, my:1, fs:1, c:0, ex:0,   ey:0, ed:1};
    apply(v, "ar_zero");
    v = '{lm:1, x:260, y:0, mx:1, my:1, fs:0, c:0, ex:0,   ey:0, ed:1};
    apply(v, "ar_step");
    v = '{lm:1, x:260, y:0, mx:1, my:1, fs:1, c:0, ex:10,  ey:0, ed:1};
    apply(v, "ar_net");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
